// File: rtl/cicero_reg_arbiter.sv
// rtl/cicero_reg_arbiter.sv - two-port round-robin arbiter and command sequencer for the AXI_top register interface
module cicero_reg_arbiter #(
   parameter int REG_WIDTH = 32,
   parameter int CMD_NOP   = 0,
   parameter int CMD_WRITE = 1,
   parameter int CMD_READ  = 2,
   parameter int RSP_LAT   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0]             req_we,
   input  logic [2*REG_WIDTH-1:0] req_addr,
   input  logic [2*REG_WIDTH-1:0] req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_id,
   output logic [REG_WIDTH-1:0]   rsp_rdata,
   output logic                   busy,
   output logic [REG_WIDTH-1:0]   address_register,
   output logic [REG_WIDTH-1:0]   data_in_register,
   output logic [REG_WIDTH-1:0]   cmd_register,
   input  logic [REG_WIDTH-1:0]   data_o_register
);

   localparam int CNT_W = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 w_grant;
   logic                 w_accept;
   logic                 r_last_grant;
   logic                 r_we;
   logic                 r_id;
   logic [REG_WIDTH-1:0] r_addr;
   logic [REG_WIDTH-1:0] r_wdata;
   logic [CNT_W-1:0]     r_cnt;

   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      w_accept  = 1'b0;
      req_ready = 2'b00;
      case (r_state)
         S_IDLE: begin
            // On contention the requester that did not win last time is served.
            w_grant = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
            if (req_valid != 2'b00 && !rst) begin
               req_ready[w_grant] = 1'b1;
               w_accept           = 1'b1;
               w_next             = S_SETUP;
            end
         end
         S_SETUP: w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign busy = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_last_grant     <= 1'b1;
         r_we             <= 1'b0;
         r_id             <= 1'b0;
         r_addr           <= '0;
         r_wdata          <= '0;
         r_cnt            <= '0;
         rsp_valid        <= 1'b0;
         rsp_id           <= 1'b0;
         rsp_rdata        <= '0;
         address_register <= '0;
         data_in_register <= '0;
         cmd_register     <= REG_WIDTH'(CMD_NOP);
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we         <= req_we[w_grant];
                  r_addr       <= w_grant ? req_addr[2*REG_WIDTH-1:REG_WIDTH]  : req_addr[REG_WIDTH-1:0];
                  r_wdata      <= w_grant ? req_wdata[2*REG_WIDTH-1:REG_WIDTH] : req_wdata[REG_WIDTH-1:0];
                  r_id         <= w_grant;
                  r_last_grant <= w_grant;
               end
            end
            S_SETUP: begin
               address_register <= r_addr;
               data_in_register <= r_wdata;
            end
            S_ISSUE: begin
               cmd_register <= r_we ? REG_WIDTH'(CMD_WRITE) : REG_WIDTH'(CMD_READ);
               r_cnt        <= CNT_W'(RSP_LAT - 1);
            end
            S_WAIT: begin
               // Counter hits zero on the edge RSP_LAT edges after the command edge.
               cmd_register <= REG_WIDTH'(CMD_NOP);
               if (r_cnt == '0) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= r_id;
                  rsp_rdata <= r_we ? '0 : data_o_register;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cicero_reg_arbiter.sv
// tb/tb_cicero_reg_arbiter.sv - directed bench for cicero_reg_arbiter with AXI_top register models
module tb_cicero_reg_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_valid2, req_we;
   logic [63:0] req_addr, req_wdata;
   logic        rsp_ready;

   logic [1:0]  req_ready1, req_ready2;
   logic        rsp_valid1, rsp_valid2, rsp_id1, rsp_id2, busy1, busy2;
   logic [31:0] rsp_rdata1, rsp_rdata2;
   logic [31:0] addr1, addr2, din1, din2, cmd1, cmd2, dout1, dout2;

   int errors = 0;
   int checks = 0;
   int n;

   bit grants[$];
   bit rsps[$];
   int pulses[$];
   int run = 0;

   logic [15:0] mem [0:3] = '{default: 16'h0};
   logic [3:0]  cnt1, cnt2;

   always #5 clk = ~clk;

   cicero_reg_arbiter #(.RSP_LAT(2)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_id(rsp_id1), .rsp_rdata(rsp_rdata1),
      .busy(busy1), .address_register(addr1), .data_in_register(din1),
      .cmd_register(cmd1), .data_o_register(dout1)
   );

   cicero_reg_arbiter #(.RSP_LAT(4)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2), .rsp_rdata(rsp_rdata2),
      .busy(busy2), .address_register(addr2), .data_in_register(din2),
      .cmd_register(cmd2), .data_o_register(dout2)
   );

   // AXI_top models: writes keep the low half-word; read data is valid only on the sample cycle.
   always @(posedge clk) begin
      if (rst) begin
         cnt1 <= 4'd0;
         cnt2 <= 4'd0;
      end else begin
         if (cmd1 == 32'd1) mem[addr1[1:0]] <= din1[15:0];
         if (cmd1 == 32'd2) cnt1 <= 4'd1;
         else if (cnt1 != 4'd0 && cnt1 != 4'd15) cnt1 <= cnt1 + 4'd1;
         if (cmd2 == 32'd2) cnt2 <= 4'd1;
         else if (cnt2 != 4'd0 && cnt2 != 4'd15) cnt2 <= cnt2 + 4'd1;
      end
   end
   assign dout1 = (cnt1 == 4'd1) ? {16'h0, mem[addr1[1:0]]} : {28'hBAD0000, cnt1};
   assign dout2 = (cnt2 == 4'd3) ? 32'h0000CAFE : {28'hBAD0000, cnt2};

   always @(negedge clk) begin
      if (!rst) begin
         if ((req_valid & req_ready1) != 2'b00) grants.push_back(req_ready1[1]);
         if (rsp_valid1 && rsp_ready) rsps.push_back(rsp_id1);
         if (cmd1 != 32'd0) run = run + 1;
         else if (run != 0) begin
            pulses.push_back(run);
            run = 0;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_one(input int id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata, input string tag);
      req_we[id]              = we;
      req_addr[id*32 +: 32]   = addr;
      req_wdata[id*32 +: 32]  = wdata;
      req_valid[id]           = 1'b1;
      #1;
      n = 0;
      while (!req_ready1[id] && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, {31'd0, req_ready1[id]}, 32'd1);
      tick();
      req_valid[id] = 1'b0;
      chk({tag, "_busy"}, {31'd0, busy1}, 32'd1);
      chk({tag, "_ready_busy"}, {30'd0, req_ready1}, 32'd0);
      tick();
      chk({tag, "_addr"}, addr1, addr);
      chk({tag, "_din"}, din1, wdata);
      chk({tag, "_cmd_setup"}, cmd1, 32'd0);
      tick();
      chk({tag, "_cmd_pulse"}, cmd1, we ? 32'd1 : 32'd2);
      tick();
      chk({tag, "_cmd_nop"}, cmd1, 32'd0);
      tick();
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid1}, 32'd1);
      chk({tag, "_rsp_id"}, {31'd0, rsp_id1}, id);
      chk({tag, "_rsp_rdata"}, rsp_rdata1, exp_rdata);
      tick();
      chk({tag, "_rsp_clear"}, {31'd0, rsp_valid1}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy1}, 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 2'b11;
      req_valid2 = 2'b00;
      req_we     = 2'b00;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b1;
      tick();
      tick();
      chk("rst_ready", {30'd0, req_ready1}, 32'd0);
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      chk("rst_cmd", cmd1, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
      chk("rst_addr", addr1, 32'd0);
      chk("rst_rdata", rsp_rdata1, 32'd0);
      req_valid = 2'b00;
      rst       = 1'b0;
      tick();

      run_one(0, 1'b1, 32'd0, 32'hDEADBEEF, 32'd0, "t1");
      run_one(1, 1'b0, 32'd0, 32'd0, 32'h0000BEEF, "t2");

      grants.delete();
      rsps.delete();
      pulses.delete();
      req_we    = 2'b00;
      req_addr  = {32'd1, 32'd0};
      req_valid = 2'b11;
      n = 0;
      while (grants.size() < 4 && n < 200) begin
         tick();
         n++;
      end
      req_valid = 2'b00;
      n = 0;
      while (busy1 && n < 50) begin
         tick();
         n++;
      end
      chk("t3_done", {31'd0, busy1}, 32'd0);
      chk("t3_grants", grants.size(), 32'd4);
      chk("t3_rsps", rsps.size(), 32'd4);
      chk("t3_pulses", pulses.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t3_grant%0d", i), {31'd0, grants[i]}, i % 2);
         chk($sformatf("t3_rsp%0d", i), {31'd0, rsps[i]}, i % 2);
         chk($sformatf("t3_pulse%0d", i), pulses[i], 32'd1);
      end

      rsp_ready = 1'b0;
      req_we[0] = 1'b0;
      req_addr  = '0;
      req_valid = 2'b01;
      #1;
      n = 0;
      while (!req_ready1[0] && n < 50) begin
         tick();
         n++;
      end
      tick();
      req_valid = 2'b00;
      n = 0;
      while (!rsp_valid1 && n < 50) begin
         tick();
         n++;
      end
      req_valid = 2'b11;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk("t4_rsp_valid", {31'd0, rsp_valid1}, 32'd1);
         chk("t4_rsp_id", {31'd0, rsp_id1}, 32'd0);
         chk("t4_rsp_rdata", rsp_rdata1, 32'h0000BEEF);
         chk("t4_busy", {31'd0, busy1}, 32'd1);
         chk("t4_ready", {30'd0, req_ready1}, 32'd0);
         tick();
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      tick();
      chk("t4_rsp_clear", {31'd0, rsp_valid1}, 32'd0);
      chk("t4_idle", {31'd0, busy1}, 32'd0);

      req_we[0]         = 1'b1;
      req_addr[31:0]    = 32'd1;
      req_wdata[31:0]   = 32'h12345678;
      req_valid         = 2'b01;
      #1;
      n = 0;
      while (!req_ready1[0] && n < 50) begin
         tick();
         n++;
      end
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      chk("t5_cmd_write", cmd1, 32'd1);
      rst = 1'b1;
      tick();
      chk("t5_cmd_nop", cmd1, 32'd0);
      chk("t5_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
      chk("t5_busy", {31'd0, busy1}, 32'd0);
      chk("t5_addr", addr1, 32'd0);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp_valid1 || busy1) n++;
      end
      chk("t5_no_rsp", n, 32'd0);
      run_one(1, 1'b0, 32'd0, 32'd0, 32'h0000BEEF, "t5_next");

      req_we[0]      = 1'b0;
      req_addr[31:0] = 32'd0;
      req_valid2     = 2'b01;
      #1;
      n = 0;
      while (!req_ready2[0] && n < 50) begin
         tick();
         n++;
      end
      chk("t6_ready", {30'd0, req_ready2}, 32'd1);
      tick();
      req_valid2 = 2'b00;
      n = 0;
      while (cmd2 == 32'd0 && n < 20) begin
         tick();
         n++;
      end
      chk("t6_cmd_read", cmd2, 32'd2);
      n = 0;
      while (!rsp_valid2 && n < 20) begin
         tick();
         n++;
      end
      chk("t6_latency", n, 32'd4);
      chk("t6_rsp_rdata", rsp_rdata2, 32'h0000CAFE);
      chk("t6_rsp_id", {31'd0, rsp_id2}, 32'd0);
      tick();
      chk("t6_idle", {31'd0, busy2}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
